tlb_op_ctrl: RTL and testbench
==============================

# tlb_op_ctrl

Sequencer for MIPS TLB instructions (TLBP/TLBR/TLBWI) retiring from the WB stage. It arbitrates TLB search port 1 away from the MEM-stage translator, drives the TLB read and write ports from CP0 EntryHi/EntryLo0/EntryLo1/Index, and emits the single-cycle `tlbp`/`tlbr`/`tlbwi` commit strobes that CP0 consumes. It signals completion with an optional refetch of the next instruction.

## Interface
- TLBNUM, 16: TLB entries; index width is log2(TLBNUM)=4.
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- req_valid  in  1  WB holds a TLB instruction.
- req_op  in  2  01=TLBP, 10=TLBR, 11=TLBWI; 00 ignored.
- req_pc  in  32  PC of the requesting instruction.
- req_ready  out  1  controller idle; the request is accepted on `req_valid&req_ready&req_op!=0&!cancel`.
- cancel  in  1  WB exception/eret flush.
- cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index  in  32 each  current CP0 values.
- s1_busy  out  1  controller owns search port 1; MEM must stall.
- s1_vpn2 / s1_odd_page / s1_asid  out  19/1/8  search key.
- s1_found / s1_index  in  1/4  search result (combinational from TLB).
- p_found / p_index  out  1/4  probe result presented to CP0 with `tlbp`.
- tlbp, tlbr, tlbwi  out  1 each  CP0 commit strobes.
- r_index  out  4  TLB read index.
- we / w_index  out  1/4  TLB write strobe and index.
- w_vpn2/w_asid/w_g/w_pfn0/w_c0/w_d0/w_v0/w_pfn1/w_c1/w_d1/w_v1  out  19/8/1/20/3/1/1/20/3/1/1  TLB write fields.
- done  out  1  one-cycle completion pulse.
- refetch / refetch_pc  out  1/32  valid with `done`: flush and refetch from `refetch_pc`.

## Operation
- States: IDLE, PROBE, PCOMMIT, READ, WRITE, DONE. Reset → IDLE.
- IDLE: `req_ready`=1. On accept, latch op and pc, then go to PROBE (TLBP), READ (TLBR), or WRITE (TLBWI). `req_op`=00 is never accepted.
- PROBE:
  - `s1_busy`=1; `s1_vpn2`=entryhi[31:13], `s1_odd_page`=entryhi[12], `s1_asid`=entryhi[7:0].
  - Register `s1_found`/`s1_index` into `p_found`/`p_index`.
  - Go to PCOMMIT.
- PCOMMIT: `tlbp`=1 for exactly this cycle; `p_*` stable. Go to DONE.
- READ: `r_index`=index[3:0]; `tlbr`=1 (CP0 samples `r_*` at this edge). Go to DONE.
- WRITE:
  - `we`=1, `tlbwi`=1, `w_index`=index[3:0].
  - `w_vpn2`=entryhi[31:13], `w_asid`=entryhi[7:0].
  - `w_g`=lo0[0]&lo1[0].
  - `w_pfnN`=loN[25:6], `w_cN`=loN[5:3], `w_dN`=loN[2], `w_vN`=loN[1].
  - Go to DONE.
- DONE:
  - `done`=1.
  - `refetch`=1 for TLBR/TLBWI and 0 for TLBP.
  - `refetch_pc`=latched pc+32'd4 (mod 2^32).
  - Go to IDLE.
- `cancel` high in any non-IDLE state:
  - Forces IDLE next cycle.
  - Combinationally suppresses `tlbp`/`tlbr`/`tlbwi`/`we`/`done`/`refetch` in that cycle.
- `cancel` in IDLE blocks acceptance.
- Outside its state, every strobe is 0. `s1_*` key outputs are 0 when `s1_busy`=0.

## Timing
- Reset (async assert, sync release): state=IDLE, `req_ready`=1, all other outputs 0, including `p_found`, `p_index`, and `refetch_pc`.
- Reset mid-operation drops `we`/strobes immediately; no partial commit is retried.
- Latency from accept edge (cycle 0):
  - TLBP: PROBE c1, `tlbp` c2, `done` c3.
  - TLBR/TLBWI: strobe c1, `done` c2.
- Back-to-back: next request is accepted in the IDLE cycle after DONE; throughput is one op per 3 (TLBR/TLBWI) or 4 (TLBP) cycles.
- `req_valid` must hold until accepted; inputs other than `cancel` are sampled only in their consuming state.

## Configuration
- `TLBOP_FAST_PROBE_EN` defined:
  - PCOMMIT is removed.
  - PROBE asserts `tlbp` with `p_found`/`p_index` passed combinationally from `s1_found`/`s1_index`.
  - TLBP `done` at c2.
- Undefined: registered probe path as above, `done` at c3.

## Test plan
- TLBP hit: entryhi=0x0000_4003, TLB returns found=1/index=5 → c1 key vpn2=0x2, asid=0x03, `s1_busy`=1; c2 `tlbp`=1, p_found=1, p_index=5; c3 `done`=1, `refetch`=0.
- TLBP miss: found=0 → c2 p_found=0, `tlbp`=1; exactly one `done`.
- TLBWI: index=7, entryhi=0x8000_2011, lo0=0x0000_1047, lo1=0x0000_0046, pc=0xBFC0_0100.
  - c1: `we`=1, w_index=7, w_vpn2=0x40001, w_asid=0x11, w_g=0, w_pfn0=0x41, w_pfn1=0x1, d/v=1/1.
  - c2: `done`=1, `refetch`=1, refetch_pc=0xBFC0_0104.
- TLBR index=3, pc=0xFFFF_FFFC → c1 r_index=3, `tlbr`=1; c2 refetch_pc=0x0000_0000.
- `cancel` asserted in PROBE → no `tlbp`, no `done`; `req_ready`=1 next cycle.
- `resetn` low during WRITE → `we`, `tlbwi` 0 immediately; after release, IDLE with all outputs at reset values.

Source files
------------

// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences TLBP/TLBR/TLBWI retiring from WB.
// Owns TLB search port 1 during probes and drives the read/write ports.
// Emits single-cycle commit strobes for CP0.
// A done pulse follows, with an optional refetch of the next PC.
// Ports: clk/resetn; req_* handshake from WB; cancel (WB flush);
//   cp0_* register values; s1_* search port; p_* probe result;
//   tlbp/tlbr/tlbwi strobes; r_index read port; we/w_* write port;
//   done/refetch/refetch_pc completion.
// Build option: TLBOP_FAST_PROBE_EN makes the probe result combinational.
//   This drops PCOMMIT, so a TLBP completes one cycle earlier.
module tlb_op_ctrl #(
    parameter int TLBNUM = 16,
    localparam int IW = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          req_valid,
    input  logic [1:0]    req_op,
    input  logic [31:0]   req_pc,
    output logic          req_ready,
    input  logic          cancel,
    input  logic [31:0]   cp0_entryhi,
    input  logic [31:0]   cp0_entrylo0,
    input  logic [31:0]   cp0_entrylo1,
    input  logic [31:0]   cp0_index,
    output logic          s1_busy,
    output logic [18:0]   s1_vpn2,
    output logic          s1_odd_page,
    output logic [7:0]    s1_asid,
    input  logic          s1_found,
    input  logic [IW-1:0] s1_index,
    output logic          p_found,
    output logic [IW-1:0] p_index,
    output logic          tlbp,
    output logic          tlbr,
    output logic          tlbwi,
    output logic [IW-1:0] r_index,
    output logic          we,
    output logic [IW-1:0] w_index,
    output logic [18:0]   w_vpn2,
    output logic [7:0]    w_asid,
    output logic          w_g,
    output logic [19:0]   w_pfn0,
    output logic [2:0]    w_c0,
    output logic          w_d0,
    output logic          w_v0,
    output logic [19:0]   w_pfn1,
    output logic [2:0]    w_c1,
    output logic          w_d1,
    output logic          w_v1,
    output logic          done,
    output logic          refetch,
    output logic [31:0]   refetch_pc
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PROBE   = 3'd1,
        S_PCOMMIT = 3'd2,
        S_READ    = 3'd3,
        S_WRITE   = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [1:0] OP_TLBP = 2'b01;

    state_t          state_q, state_d;
    logic [1:0]      op_q, op_d;
    logic [31:0]     pc_q, pc_d;
    logic            pf_q, pf_d;
    logic [IW-1:0]   pi_q, pi_d;
    logic            accept;

    assign accept = req_valid && (state_q == S_IDLE)
                    && (req_op != 2'b00) && !cancel;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            op_q    <= 2'b00;
            pc_q    <= 32'd0;
            pf_q    <= 1'b0;
            pi_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            pc_q    <= pc_d;
            pf_q    <= pf_d;
            pi_q    <= pi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        pc_d        = pc_q;
        pf_d        = pf_q;
        pi_d        = pi_q;
        req_ready   = 1'b0;
        s1_busy     = 1'b0;
        s1_vpn2     = '0;
        s1_odd_page = 1'b0;
        s1_asid     = '0;
        p_found     = pf_q;
        p_index     = pi_q;
        tlbp        = 1'b0;
        tlbr        = 1'b0;
        tlbwi       = 1'b0;
        r_index     = '0;
        we          = 1'b0;
        w_index     = '0;
        w_vpn2      = '0;
        w_asid      = '0;
        w_g         = 1'b0;
        w_pfn0      = '0;
        w_c0        = '0;
        w_d0        = 1'b0;
        w_v0        = 1'b0;
        w_pfn1      = '0;
        w_c1        = '0;
        w_d1        = 1'b0;
        w_v1        = 1'b0;
        done        = 1'b0;
        refetch     = 1'b0;
        refetch_pc  = '0;

        unique case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    op_d = req_op;
                    pc_d = req_pc;
                    unique case (req_op)
                        2'b01:   state_d = S_PROBE;
                        2'b10:   state_d = S_READ;
                        default: state_d = S_WRITE;
                    endcase
                end
            end
            S_PROBE: begin
                s1_busy     = 1'b1;
                s1_vpn2     = cp0_entryhi[31:13];
                s1_odd_page = cp0_entryhi[12];
                s1_asid     = cp0_entryhi[7:0];
                if (!cancel) begin
                    pf_d = s1_found;
                    pi_d = s1_index;
                end
`ifdef TLBOP_FAST_PROBE_EN
                p_found = s1_found;
                p_index = s1_index;
                tlbp    = !cancel;
                state_d = S_DONE;
`else
                state_d = S_PCOMMIT;
`endif
            end
`ifndef TLBOP_FAST_PROBE_EN
            S_PCOMMIT: begin
                tlbp    = !cancel;
                state_d = S_DONE;
            end
`endif
            S_READ: begin
                r_index = cp0_index[IW-1:0];
                tlbr    = !cancel;
                state_d = S_DONE;
            end
            S_WRITE: begin
                we      = !cancel;
                tlbwi   = !cancel;
                w_index = cp0_index[IW-1:0];
                w_vpn2  = cp0_entryhi[31:13];
                w_asid  = cp0_entryhi[7:0];
                // Global only if both halves agree, as in MIPS32.
                w_g     = cp0_entrylo0[0] & cp0_entrylo1[0];
                w_pfn0  = cp0_entrylo0[25:6];
                w_c0    = cp0_entrylo0[5:3];
                w_d0    = cp0_entrylo0[2];
                w_v0    = cp0_entrylo0[1];
                w_pfn1  = cp0_entrylo1[25:6];
                w_c1    = cp0_entrylo1[5:3];
                w_d1    = cp0_entrylo1[2];
                w_v1    = cp0_entrylo1[1];
                state_d = S_DONE;
            end
            S_DONE: begin
                done       = !cancel;
                // TLBP changes no mapping, so no refetch is needed.
                refetch    = !cancel && (op_q != OP_TLBP);
                refetch_pc = pc_q + 32'd4;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (cancel && state_q != S_IDLE)
            state_d = S_IDLE;
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Randomized bench for tlb_op_ctrl against a per-cycle timeline model.
// Covers directed cases first, then random ops with random cancels.
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid;
    logic [1:0]  req_op;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        cancel;
    logic [31:0] cp0_entryhi, cp0_entrylo0, cp0_entrylo1, cp0_index;
    logic        s1_busy;
    logic [18:0] s1_vpn2;
    logic        s1_odd_page;
    logic [7:0]  s1_asid;
    logic        s1_found;
    logic [3:0]  s1_index;
    logic        p_found;
    logic [3:0]  p_index;
    logic        tlbp, tlbr, tlbwi;
    logic [3:0]  r_index;
    logic        we;
    logic [3:0]  w_index;
    logic [18:0] w_vpn2;
    logic [7:0]  w_asid;
    logic        w_g;
    logic [19:0] w_pfn0, w_pfn1;
    logic [2:0]  w_c0, w_c1;
    logic        w_d0, w_v0, w_d1, w_v1;
    logic        done, refetch;
    logic [31:0] refetch_pc;

    tlb_op_ctrl #(.TLBNUM(16)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_op(req_op), .req_pc(req_pc),
        .req_ready(req_ready), .cancel(cancel),
        .cp0_entryhi(cp0_entryhi), .cp0_entrylo0(cp0_entrylo0),
        .cp0_entrylo1(cp0_entrylo1), .cp0_index(cp0_index),
        .s1_busy(s1_busy), .s1_vpn2(s1_vpn2),
        .s1_odd_page(s1_odd_page), .s1_asid(s1_asid),
        .s1_found(s1_found), .s1_index(s1_index),
        .p_found(p_found), .p_index(p_index),
        .tlbp(tlbp), .tlbr(tlbr), .tlbwi(tlbwi),
        .r_index(r_index), .we(we), .w_index(w_index),
        .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
        .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
        .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
        .done(done), .refetch(refetch), .refetch_pc(refetch_pc)
    );

    always #5 clk = ~clk;

`ifdef TLBOP_FAST_PROBE_EN
    localparam int PLAT = 2;
`else
    localparam int PLAT = 3;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Expected values for the current cycle.
    logic [7:0]  e_str;   // ready,busy,tlbp,tlbr,tlbwi,we,done,refetch
    logic [27:0] e_key;   // vpn2,odd,asid
    logic [3:0]  e_rix;
    logic [81:0] e_w;     // w_index + write fields
    logic [31:0] e_rpc;
    logic        e_pchk;
    logic [4:0]  e_p;

    task automatic clr();
        e_str = '0; e_key = '0; e_rix = '0;
        e_w = '0; e_rpc = '0; e_pchk = 1'b0; e_p = '0;
    endtask

    task automatic chk(input string tag, input logic [127:0] o,
                       input logic [127:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic cmp_all(input string tag);
        chk({tag, ".strobes"},
            {120'd0, req_ready, s1_busy, tlbp, tlbr, tlbwi,
             we, done, refetch}, {120'd0, e_str});
        chk({tag, ".key"}, {100'd0, s1_vpn2, s1_odd_page, s1_asid},
            {100'd0, e_key});
        chk({tag, ".r_index"}, {124'd0, r_index}, {124'd0, e_rix});
        chk({tag, ".wfields"},
            {46'd0, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0,
             w_v0, w_pfn1, w_c1, w_d1, w_v1}, {46'd0, e_w});
        chk({tag, ".refetch_pc"}, {96'd0, refetch_pc}, {96'd0, e_rpc});
        if (e_pchk)
            chk({tag, ".probe"}, {123'd0, p_found, p_index},
                {123'd0, e_p});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write-port image derived from MIPS EntryHi/EntryLo field layout.
    function automatic logic [81:0] wimg(input logic [31:0] ix, eh,
                                         lo0, lo1);
        logic [3:0]  i;
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pf0, pf1;
        logic [2:0]  c0, c1;
        logic        d0, v0, d1, v1;
        i    = 4'(ix % 16);
        vpn2 = 19'(eh / 8192);
        asid = 8'(eh % 256);
        g    = ((lo0 % 2) == 1) && ((lo1 % 2) == 1);
        pf0  = 20'((lo0 / 64) % (1 << 20));
        pf1  = 20'((lo1 / 64) % (1 << 20));
        c0   = 3'((lo0 / 8) % 8);
        c1   = 3'((lo1 / 8) % 8);
        d0   = ((lo0 / 4) % 2) == 1;
        d1   = ((lo1 / 4) % 2) == 1;
        v0   = ((lo0 / 2) % 2) == 1;
        v1   = ((lo1 / 2) % 2) == 1;
        return {i, vpn2, asid, g, pf0, c0, d0, v0, pf1, c1, d1, v1};
    endfunction

    // One instruction: accept cycle then its timeline.
    // cat = cycle (1..n) where cancel is raised, 0 for none.
    task automatic do_op(input logic [1:0] op, input logic [31:0] eh,
                         input logic [31:0] lo0, input logic [31:0] lo1,
                         input logic [31:0] ix, input logic [31:0] pc,
                         input logic fnd, input logic [3:0] si,
                         input int cat);
        int n;
        logic can;
        n = (op == 2'b01) ? PLAT : 2;
        req_valid = 1'b1; req_op = op; req_pc = pc;
        cp0_entryhi = eh; cp0_entrylo0 = lo0;
        cp0_entrylo1 = lo1; cp0_index = ix;
        cancel = 1'b0;
        #1;
        clr(); e_str[7] = 1'b1;
        cmp_all("accept");
        tick();
        req_valid = 1'b0;
        req_op = 2'($urandom);
        req_pc = $urandom;
        for (int c = 1; c <= n; c++) begin
            can = (c == cat);
            cancel = can;
            s1_found = fnd; s1_index = si;
            #1;
            clr();
            if (op == 2'b01 && c == 1) begin
                e_str[6] = 1'b1;
                e_key = {19'(eh / 8192), 1'((eh / 4096) % 2),
                         8'(eh % 256)};
                if (n == 2) begin
                    e_str[5] = !can;
                    e_pchk = 1'b1; e_p = {fnd, si};
                end
            end else if (op == 2'b01 && c == 2 && n == 3) begin
                e_str[5] = !can;
                e_pchk = 1'b1; e_p = {fnd, si};
            end else if (c < n) begin
                if (op == 2'b10) begin
                    e_str[4] = !can;
                    e_rix = 4'(ix % 16);
                end else begin
                    e_str[3] = !can; e_str[2] = !can;
                    e_w = wimg(ix, eh, lo0, lo1);
                end
            end else begin
                e_str[1] = !can;
                e_str[0] = !can && (op != 2'b01);
                e_rpc = pc + 32'd4;
            end
            cmp_all($sformatf("op%0d.c%0d%s", op, c, can ? ".cxl" : ""));
            tick();
            if (can) begin
                cancel = 1'b0;
                #1;
                chk("cancel.ready", {127'd0, req_ready}, 128'd1);
                break;
            end
        end
    endtask

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_pc = '0;
        cancel = 1'b0; cp0_entryhi = '0; cp0_entrylo0 = '0;
        cp0_entrylo1 = '0; cp0_index = '0; s1_found = 1'b0;
        s1_index = '0;
        #3;
        clr(); e_str[7] = 1'b1; e_pchk = 1'b1;
        cmp_all("reset");
        @(negedge clk);
        resetn = 1'b1;
        tick();

        // Directed: probe hit, then mid-write reset.
        do_op(2'b01, 32'h0000_4003, 0, 0, 0, 32'h100, 1'b1, 4'd5, 0);
        req_valid = 1'b1; req_op = 2'b11; cp0_index = 32'd7;
        cp0_entryhi = 32'h8000_2011;
        tick();
        req_valid = 1'b0;
        #1;
        chk("rst.we_before", {126'd0, we, tlbwi}, 128'd3);
        resetn = 1'b0;
        #1;
        chk("rst.we_after", {126'd0, we, tlbwi}, 128'd0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        #1;
        clr(); e_str[7] = 1'b1; e_pchk = 1'b1;
        cmp_all("post_reset");

        // Directed plan cases.
        do_op(2'b01, 32'h0000_4003, 0, 0, 0, 32'h200, 1'b0, 4'd9, 0);
        do_op(2'b11, 32'h8000_2011, 32'h0000_1047, 32'h0000_0046,
              32'd7, 32'hBFC0_0100, 1'b0, 4'd0, 0);
        do_op(2'b10, 0, 0, 0, 32'd3, 32'hFFFF_FFFC, 1'b0, 4'd0, 0);
        do_op(2'b01, 32'h1234_5678, 0, 0, 0, 32'h300, 1'b1, 4'd2, 1);

        // Op 00 and cancel in IDLE must not be accepted.
        req_valid = 1'b1; req_op = 2'b00;
        tick();
        req_op = 2'b11; cancel = 1'b1;
        #1;
        chk("op00.ready", {127'd0, req_ready}, 128'd1);
        tick();
        cancel = 1'b0; req_valid = 1'b0;
        #1;
        chk("idlecxl.ready", {127'd0, req_ready}, 128'd1);
        chk("idlecxl.we", {127'd0, we}, 128'd0);

        for (int k = 0; k < 60; k++) begin
            logic [1:0] op;
            int cat;
            op = 2'($urandom_range(1, 3));
            cat = ($urandom_range(0, 3) == 0) ?
                  $urandom_range(1, (op == 2'b01) ? PLAT : 2) : 0;
            do_op(op, $urandom, $urandom, $urandom, $urandom, $urandom,
                  1'($urandom), 4'($urandom), cat);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
